// File: rtl/oled_spi_sink_if.sv
// SPI link from the OLED controller to the panel-side receiver.
interface oled_spi_sink_if;
    logic sclk;
    logic sdin;
    logic dc;
    logic res_n;

    modport master (output sclk, output sdin, output dc, output res_n);
    modport slave  (input  sclk, input  sdin, input  dc, input  res_n);
endinterface

// File: rtl/oled_spi_sink.sv
// Panel-side SPI receiver: oversampled byte assembly, SSD1306 command
// subset decode, and a local GDDRAM image with a registered read port.
module oled_spi_sink #(
    parameter  int unsigned COLS         = 128,
    parameter  int unsigned PAGES        = 4,
    parameter  int unsigned SYNC_STAGES  = 2,
    parameter  int unsigned IDLE_TIMEOUT = 1024,
    localparam int unsigned ADDR_W       = $clog2(COLS * PAGES)
) (
    input  logic              clk,
    input  logic              rst,
    oled_spi_sink_if.slave    spi,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              byte_dc,
    output logic              disp_on,
    output logic              entire_on,
    output logic [1:0]        addr_mode,
    input  logic [ADDR_W-1:0] ram_rd_addr,
    output logic [7:0]        ram_rd_data
);
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned PAGE_W = $clog2(PAGES);
    localparam int unsigned TO_W   = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARG1, ST_ARG2} dec_state_e;

    // Synchronizer lanes: [0] sclk, [1] sdin, [2] dc, [3] res_n
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0] sync_out;
    logic       sclk_s, sdin_s, dc_s, res_n_s, loc_rst;

    logic              sclk_prev_q, sclk_prev_d, rise_q, rise_d;
    logic              sdin_r_q, sdin_r_d, dc_r_q, dc_r_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic              byte_valid_q, byte_valid_d, byte_dc_q, byte_dc_d;
    logic [7:0]        byte_data_q, byte_data_d;
    logic              disp_on_q, disp_on_d, entire_on_q, entire_on_d;
    logic [1:0]        addr_mode_q, addr_mode_d;
    logic [COL_W-1:0]  col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PAGE_W-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    dec_state_e        state_q, state_d;
    logic [7:0]        op_q, op_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;
    logic [COL_W-1:0]  col_inc;
    logic [PAGE_W-1:0] page_inc;
    logic [7:0]        col8;
    logic [7:0]        mem_q [COLS*PAGES];
    logic [7:0]        ram_rd_data_q;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sclk_s   = sync_out[0];
    assign sdin_s   = sync_out[1];
    assign dc_s     = sync_out[2];
    assign res_n_s  = sync_out[3];
    assign loc_rst  = rst | ~res_n_s;

    // Input synchronization, sclk edge detection and byte assembly
    always_comb begin
        sync_d = sync_q;
        sync_d[0] = {spi.res_n, spi.dc, spi.sdin, spi.sclk};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        if (rst) sync_d = {SYNC_STAGES{4'b1001}};

        // Edge and the sampled sdin/dc are registered together so the shift
        // sees bits aligned with the edge one cycle after synchronization.
        sclk_prev_d  = sclk_s;
        rise_d       = sclk_s & ~sclk_prev_q;
        sdin_r_d     = sdin_s;
        dc_r_d       = dc_s;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        idle_cnt_d   = '0;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        byte_dc_d    = byte_dc_q;

        if (rise_q) begin
            shift_d = {shift_q[5:0], sdin_r_q};
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_data_d  = {shift_q, sdin_r_q};
                byte_dc_d    = dc_r_q;
                bit_cnt_d    = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end else if (sclk_s && bit_cnt_q != '0) begin
            if (idle_cnt_q == TO_W'(IDLE_TIMEOUT - 1)) begin
                bit_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
        end

        if (loc_rst) begin
            rise_d       = 1'b0;
            bit_cnt_d    = '0;
            idle_cnt_d   = '0;
            byte_valid_d = 1'b0;
            byte_data_d  = '0;
            byte_dc_d    = 1'b0;
        end
    end

    // Command/argument decode, data write and pointer advance
    always_comb begin
        disp_on_d    = disp_on_q;
        entire_on_d  = entire_on_q;
        addr_mode_d  = addr_mode_q;
        col_d        = col_q;
        page_d       = page_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        state_d      = state_q;
        op_d         = op_q;
        ram_we       = 1'b0;
        ram_wa       = ADDR_W'(32'(page_q) * COLS + 32'(col_q));
        col_inc      = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
        page_inc     = (page_q == PAGE_W'(PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
        col8         = 8'(col_q);

        if (byte_valid_q) begin
            if (byte_dc_q) begin
                state_d = ST_IDLE;
                ram_we  = 1'b1;
                case (addr_mode_q)
                    2'd0: begin
                        if (col_q == col_end_q) begin
                            col_d  = col_start_q;
                            page_d = (page_q == page_end_q) ? page_start_q : page_inc;
                        end else begin
                            col_d = col_inc;
                        end
                    end
                    2'd1: begin
                        if (page_q == page_end_q) begin
                            page_d = page_start_q;
                            col_d  = (col_q == col_end_q) ? col_start_q : col_inc;
                        end else begin
                            page_d = page_inc;
                        end
                    end
                    default: col_d = col_inc;
                endcase
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        op_d = byte_data_q;
                        case (byte_data_q) inside
                            8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8,
                            8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: state_d = ST_ARG1;
                            8'hAE, 8'hAF:   disp_on_d   = byte_data_q[0];
                            8'hA4, 8'hA5:   entire_on_d = byte_data_q[0];
                            [8'hB0:8'hB7]:  page_d = PAGE_W'(32'(byte_data_q[2:0]) % PAGES);
                            [8'h00:8'h0F]:  col_d  = COL_W'({col8[7:4], byte_data_q[3:0]});
                            [8'h10:8'h1F]:  col_d  = COL_W'({byte_data_q[3:0], col8[3:0]});
                            default: ;
                        endcase
                    end
                    ST_ARG1: begin
                        state_d = ST_IDLE;
                        case (op_q)
                            8'h20: if (byte_data_q[1:0] != 2'd3) addr_mode_d = byte_data_q[1:0];
                            8'h21: begin
                                col_start_d = COL_W'(byte_data_q);
                                state_d     = ST_ARG2;
                            end
                            8'h22: begin
                                page_start_d = PAGE_W'(32'(byte_data_q) % PAGES);
                                state_d      = ST_ARG2;
                            end
                            default: ;
                        endcase
                    end
                    default: begin
                        state_d = ST_IDLE;
                        if (op_q == 8'h21) begin
                            col_end_d = COL_W'(byte_data_q);
                            col_d     = col_start_q;
                        end else begin
                            page_end_d = PAGE_W'(32'(byte_data_q) % PAGES);
                            page_d     = page_start_q;
                        end
                    end
                endcase
            end
        end

        if (loc_rst) begin
            disp_on_d    = 1'b0;
            entire_on_d  = 1'b0;
            addr_mode_d  = 2'd2;
            col_d        = '0;
            page_d       = '0;
            col_start_d  = '0;
            col_end_d    = COL_W'(COLS - 1);
            page_start_d = '0;
            page_end_d   = PAGE_W'(PAGES - 1);
            state_d      = ST_IDLE;
            op_d         = '0;
            ram_we       = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        sync_q       <= sync_d;
        sclk_prev_q  <= sclk_prev_d;
        rise_q       <= rise_d;
        sdin_r_q     <= sdin_r_d;
        dc_r_q       <= dc_r_d;
        bit_cnt_q    <= bit_cnt_d;
        shift_q      <= shift_d;
        idle_cnt_q   <= idle_cnt_d;
        byte_valid_q <= byte_valid_d;
        byte_data_q  <= byte_data_d;
        byte_dc_q    <= byte_dc_d;
        disp_on_q    <= disp_on_d;
        entire_on_q  <= entire_on_d;
        addr_mode_q  <= addr_mode_d;
        col_q        <= col_d;
        page_q       <= page_d;
        col_start_q  <= col_start_d;
        col_end_q    <= col_end_d;
        page_start_q <= page_start_d;
        page_end_q   <= page_end_d;
        state_q      <= state_d;
        op_q         <= op_d;
    end

    // GDDRAM image: no reset, read-first on same-address collision
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_wa] <= byte_data_q;
        ram_rd_data_q <= mem_q[ram_rd_addr];
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_dc     = byte_dc_q;
    assign disp_on     = disp_on_q;
    assign entire_on   = entire_on_q;
    assign addr_mode   = addr_mode_q;
    assign ram_rd_data = ram_rd_data_q;
endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink with a behavioural panel model.
module tb_oled_spi_sink;
    localparam int COLS  = 128;
    localparam int PAGES = 4;
    localparam int SYNC  = 2;
    localparam int TO    = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid, byte_dc, disp_on, entire_on;
    logic [7:0] byte_data, ram_rd_data;
    logic [1:0] addr_mode;
    logic [8:0] ram_rd_addr;

    oled_spi_sink_if spi ();

    oled_spi_sink #(
        .COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SYNC), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .spi(spi),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
        .disp_on(disp_on), .entire_on(entire_on), .addr_mode(addr_mode),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;
    longint cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Panel model, in terms of column/page coordinates
    int m_ram [COLS*PAGES];
    bit m_known [COLS*PAGES];
    int m_disp, m_entire, m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_argn, m_op;

    function automatic void model_reset();
        m_disp = 0; m_entire = 0; m_mode = 2;
        m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
        m_argn = 0; m_op = 0;
    endfunction

    function automatic void model_byte(input int b, input bit d);
        int a;
        if (d) begin
            m_argn = 0;
            a = m_page * COLS + m_col;
            m_ram[a] = b;
            m_known[a] = 1'b1;
            if (m_mode == 0) begin
                if (m_col == m_ce) begin
                    m_col = m_cs;
                    m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
                end else m_col = (m_col + 1) % COLS;
            end else if (m_mode == 1) begin
                if (m_page == m_pe) begin
                    m_page = m_ps;
                    m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS;
                end else m_page = (m_page + 1) % PAGES;
            end else m_col = (m_col + 1) % COLS;
        end else if (m_argn == 1) begin
            m_argn = 0;
            if (m_op == 'h20 && b % 4 != 3) m_mode = b % 4;
            if (m_op == 'h21) begin m_cs = b % COLS; m_argn = 2; end
            if (m_op == 'h22) begin m_ps = b % PAGES; m_argn = 2; end
        end else if (m_argn == 2) begin
            m_argn = 0;
            if (m_op == 'h21) begin m_ce = b % COLS; m_col = m_cs; end
            else begin m_pe = b % PAGES; m_page = m_ps; end
        end else begin
            m_op = b;
            if (b inside {'h20, 'h21, 'h22, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) m_argn = 1;
            else if (b == 'hAE || b == 'hAF) m_disp = b - 'hAE;
            else if (b == 'hA4 || b == 'hA5) m_entire = b - 'hA4;
            else if (b >= 'hB0 && b <= 'hB7) m_page = (b - 'hB0) % PAGES;
            else if (b < 'h10) m_col = m_col - (m_col % 16) + b;
            else if (b < 'h20) m_col = ((b - 'h10) * 16 + m_col % 16) % COLS;
        end
    endfunction

    typedef struct { int b; bit d; longint edge_cyc; } exp_t;
    exp_t q[$];

    // Every cycle: status vs model, and each received byte vs the expected stream
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("disp_on", disp_on, m_disp);
            check("entire_on", entire_on, m_entire);
            check("addr_mode", addr_mode, m_mode);
        end
        if (byte_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no byte_valid", byte_data);
            end else begin
                e = q.pop_front();
                check("byte_data", byte_data, e.b);
                check("byte_dc", byte_dc, e.d);
                check("latency", int'(cyc - e.edge_cyc), SYNC + 1);
                model_byte(e.b, e.d);
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input bit d, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            spi.sclk = 1'b0;
            spi.sdin = b[7-i];
            spi.dc   = d;
            repeat (3) @(negedge clk);
            spi.sclk = 1'b1;
            if (i == 7 && push) q.push_back('{int'(b), d, cyc + 1});
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_bits(b, 1'b0, 8, 1'b1);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_bits(b, 1'b1, 8, 1'b1);
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
        check("pending_bytes", q.size(), 0);
    endtask

    task automatic do_rst(input int n);
        chk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (n) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic do_resn(input int n);
        chk_en = 1'b0;
        @(negedge clk);
        spi.res_n = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        spi.res_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic rd(input int a, input int lit);
        @(negedge clk);
        ram_rd_addr = 9'(a);
        @(negedge clk);
        check($sformatf("ram_%0h", a), ram_rd_data, lit);
        if (m_known[a]) check($sformatf("ram_model_%0h", a), ram_rd_data, m_ram[a]);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        spi.sclk = 1'b1; spi.sdin = 1'b0; spi.dc = 1'b0; spi.res_n = 1'b1;
        ram_rd_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_byte_valid", byte_valid, 0);
        check("rst_disp_on", disp_on, 0);
        check("rst_entire_on", entire_on, 0);
        check("rst_addr_mode", addr_mode, 2);
        chk_en = 1'b1;

        // RAM survives rst
        send_data(8'hC3);
        drain();
        do_rst(3);
        rd('h000, 'hC3);

        // Display on
        send_cmd(8'hAF);
        drain();
        check("disp_on_lit", disp_on, 1);
        rd('h000, 'hC3);

        // Page mode addressing with nibble column set
        send_cmd(8'hB2); send_cmd(8'h05); send_cmd(8'h13);
        send_data(8'h3C); send_data(8'h5A);
        drain();
        rd('h135, 'h3C);
        rd('h136, 'h5A);

        // Horizontal mode, 2-column window wraps back
        send_cmd(8'h20); send_cmd(8'h00);
        send_cmd(8'h21); send_cmd(8'h7E); send_cmd(8'h7F);
        send_cmd(8'h22); send_cmd(8'h03); send_cmd(8'h03);
        send_data(8'h11); send_data(8'h22); send_data(8'h33);
        drain();
        check("addr_mode_h", addr_mode, 0);
        rd('h1FE, 'h33);
        rd('h1FF, 'h22);

        // Partial byte dropped after idle timeout
        send_bits(8'hF8, 1'b0, 5, 1'b0);
        repeat (TO + 10) @(negedge clk);
        send_cmd(8'hA5);
        drain();
        check("entire_on_lit", entire_on, 1);

        // Mode 3 ignored; data byte aborts a pending argument
        send_cmd(8'h20); send_cmd(8'h03);
        send_cmd(8'h81); send_data(8'h44);
        drain();
        check("addr_mode_keep", addr_mode, 0);
        rd('h1FF, 'h44);

        // Vertical mode inside a 2x2 window
        send_cmd(8'h20); send_cmd(8'h01);
        send_cmd(8'h21); send_cmd(8'h05); send_cmd(8'h06);
        send_cmd(8'h22); send_cmd(8'h01); send_cmd(8'h02);
        send_data(8'hA1); send_data(8'hA2); send_data(8'hA3); send_data(8'hA4);
        drain();
        rd('h085, 'hA1);
        rd('h105, 'hA2);
        rd('h086, 'hA3);
        rd('h106, 'hA4);

        // rst in the middle of a byte loses it
        send_bits(8'h5A, 1'b0, 4, 1'b0);
        do_rst(2);
        send_cmd(8'hAF);
        drain();
        check("addr_mode_after_rst", addr_mode, 2);
        check("disp_on_after_rst", disp_on, 1);

        // res_n mid-argument clears decoder and pointers, RAM kept
        send_cmd(8'h20); send_cmd(8'h00); send_cmd(8'hB1); send_cmd(8'h03);
        send_cmd(8'h21); send_cmd(8'h10);
        drain();
        do_resn(4);
        send_data(8'h77);
        drain();
        check("addr_mode_resn", addr_mode, 2);
        check("disp_on_resn", disp_on, 0);
        rd('h000, 'h77);
        rd('h135, 'h3C);
        rd('h085, 'hA1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
